lfsr_stream_decryptor: RTL

- Hardware decrypt engine for the LFSR message-encryption format: 64 ciphertext bytes, each equal to plaintext XOR LFSR state k.
- Plaintext is space-padded, with at least 9 leading 0x20 bytes. The block uses those 9 known spaces to recover the seed and which of the 8 legal tap patterns was used.
- It then decrypts the rest of the stream and emits the message with all leading spaces stripped.
- Sits between the ciphertext buffer (data memory 64..127) and the plaintext writer (data memory 0..), as a hardware counterpart to the program-3 software decrypt.

---
 rtl/lfsr_stream_decryptor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lfsr_stream_decryptor.sv
// Recovers LFSR seed and tap from a known space preamble, then decrypts
// the rest of the 64-byte stream and emits it with leading spaces stripped.
module lfsr_stream_decryptor #(
   parameter int         MSG_LEN  = 64,
   parameter int         PRE_MIN  = 9,
   parameter logic [7:0] PAD_CHAR = 8'h20
) (
   input  logic       i_clk,
   input  logic       i_init_n,
   input  logic       i_start,
   input  logic [7:0] i_in_data,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic [7:0] o_out_data,
   output logic       o_out_valid,
   input  logic       i_out_ready,
   output logic       o_out_last,
   output logic [2:0] o_tap_sel,
   output logic [7:0] o_lfsr_seed,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam logic [5:0] K_LAST = 6'(MSG_LEN - 1);
   localparam logic [5:0] K_TRN  = 6'(PRE_MIN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_TRAIN, S_DECRYPT, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   function automatic logic [7:0] f_tap(input logic [2:0] i);
      logic [7:0] t;
      case (i)
         3'd0:    t = 8'hE1;
         3'd1:    t = 8'hD4;
         3'd2:    t = 8'hC6;
         3'd3:    t = 8'hB8;
         3'd4:    t = 8'hB4;
         3'd5:    t = 8'hB2;
         3'd6:    t = 8'hFA;
         default: t = 8'hF3;
      endcase
      return t;
   endfunction

   function automatic logic [7:0] f_step(input logic [7:0] s,
                                         input logic [7:0] t);
      return {s[6:0], ^(s & t)};
   endfunction

   state_t     r_state, w_next;
   logic [5:0] r_k;
   logic [7:0] r_cand [8];
   logic [7:0] r_ok;
   logic [7:0] r_lfsr;
   logic [2:0] r_tap;
   logic [7:0] r_seed;
   logic       r_seen;
   logic [7:0] r_out_data;
   logic       r_out_valid;
   logic       r_out_last;

   logic       w_xfer;
   logic [7:0] w_key;
   logic [7:0] w_cstep [8];
   logic [7:0] w_ok;
   logic [2:0] w_low;
   logic [7:0] w_dstep;
   logic [7:0] w_p;
   logic       w_emit;
   logic       w_start_ok;

   assign w_xfer     = i_in_valid && o_in_ready;
   assign w_key      = i_in_data ^ PAD_CHAR;
   assign w_dstep    = f_step(r_lfsr, f_tap(r_tap));
   assign w_p        = i_in_data ^ w_dstep;
   assign w_emit     = r_seen || (w_p != PAD_CHAR) || (r_k == K_LAST);
   assign w_start_ok = i_start && (r_state == S_IDLE ||
                       r_state == S_DONE || r_state == S_ERROR);

   // Every candidate steps in parallel; lowest surviving index wins.
   always_comb begin
      w_low = 3'd0;
      for (int i = 0; i < 8; i++) begin
         w_cstep[i] = f_step(r_cand[i], f_tap(3'(i)));
         w_ok[i]    = r_ok[i] && (w_cstep[i] == w_key);
      end
      for (int i = 7; i >= 0; i--) begin
         if (w_ok[i]) w_low = 3'(i);
      end
   end

   always_comb begin
      w_next     = r_state;
      o_in_ready = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_SEED;
         end
         S_SEED: begin
            o_in_ready = 1'b1;
            if (w_xfer) w_next = (w_key == 8'h00) ? S_ERROR : S_TRAIN;
         end
         S_TRAIN: begin
            o_in_ready = 1'b1;
            if (w_xfer && r_k == K_TRN)
               w_next = (w_ok == 8'h00) ? S_ERROR : S_DECRYPT;
         end
         S_DECRYPT: begin
            o_in_ready = !r_out_valid || i_out_ready;
            if (w_xfer && r_k == K_LAST) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_out_valid && i_out_ready) w_next = S_DONE;
         end
         S_DONE, S_ERROR: begin
            if (i_start) w_next = S_SEED;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_init_n) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (!i_init_n) begin
         r_k         <= '0;
         r_ok        <= '0;
         r_lfsr      <= '0;
         r_tap       <= '0;
         r_seed      <= '0;
         r_seen      <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         for (int i = 0; i < 8; i++) r_cand[i] <= '0;
      end else begin
         if (w_start_ok) r_k <= '0;
         if (r_state == S_SEED && w_xfer) begin
            for (int i = 0; i < 8; i++) r_cand[i] <= w_key;
            r_ok   <= 8'hFF;
            r_seed <= w_key;
            r_seen <= 1'b0;
            r_k    <= 6'd1;
         end
         if (r_state == S_TRAIN && w_xfer) begin
            for (int i = 0; i < 8; i++) r_cand[i] <= w_cstep[i];
            r_ok <= w_ok;
            r_k  <= r_k + 6'd1;
            if (r_k == K_TRN) begin
               r_tap  <= w_low;
               r_lfsr <= w_cstep[w_low];
            end
         end
         if (r_state == S_DECRYPT && w_xfer) begin
            r_lfsr <= w_dstep;
            if (w_p != PAD_CHAR) r_seen <= 1'b1;
            if (r_k != K_LAST)   r_k <= r_k + 6'd1;
         end
         // One-entry output register: a new byte overwrites, else a take empties it.
         if (r_state == S_DECRYPT && w_xfer && w_emit) begin
            r_out_data  <= w_p;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_k == K_LAST);
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;
   assign o_tap_sel   = r_tap;
   assign o_lfsr_seed = r_seed;
   assign o_busy      = (r_state == S_SEED) || (r_state == S_TRAIN) ||
                        (r_state == S_DECRYPT);
   assign o_done      = (r_state == S_DONE);
   assign o_err       = (r_state == S_ERROR);

endmodule
